// File: rtl/guess_engine.sv
// Number-guessing game core: synchronised buttons, LFSR secret, compare FSM, 7-seg glyph.
// Latency: outputs update 3 clk edges after a raw button rise; no backpressure (pulses dropped while ena=0).
module guess_engine #(
    parameter int          GUESS_W   = 6,
    parameter int          MAX_TRIES = 8,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic [GUESS_W-1:0] guess_in,
    input  logic               submit_btn,
    input  logic               newgame_btn,
    output logic [1:0]         result,
    output logic [3:0]         attempts,
    output logic [1:0]         game_state,
    output logic [6:0]         seg,
    output logic [GUESS_W-1:0] secret_o
);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_PLAY = 2'b01;
    localparam logic [1:0] ST_WON  = 2'b10;
    localparam logic [1:0] ST_LOST = 2'b11;

    localparam logic [1:0] RES_NONE = 2'b00;
    localparam logic [1:0] RES_LOW  = 2'b01;
    localparam logic [1:0] RES_HIGH = 2'b10;
    localparam logic [1:0] RES_OK   = 2'b11;

    localparam logic [3:0] MAX_T = 4'(MAX_TRIES);

    localparam logic [6:0] SEG_DASH = 7'b1000000;
    localparam logic [6:0] SEG_L    = 7'b0111000;
    localparam logic [6:0] SEG_H    = 7'b1110110;
    localparam logic [6:0] SEG_C    = 7'b0111001;
    localparam logic [6:0] SEG_E    = 7'b1111001;

    logic               sub_s1_q, sub_s1_d, sub_s2_q, sub_s2_d, sub_prev_q, sub_prev_d;
    logic               ng_s1_q, ng_s1_d, ng_s2_q, ng_s2_d, ng_prev_q, ng_prev_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic [1:0]         state_q, state_d;
    logic [1:0]         result_q, result_d;
    logic [3:0]         attempts_q, attempts_d;
    logic [GUESS_W-1:0] secret_q, secret_d;
    logic [6:0]         seg_q, seg_d;

    logic               sub_pulse, ng_pulse, lfsr_fb;
    logic [3:0]         att_inc;

    assign sub_pulse = sub_s2_q & ~sub_prev_q;
    assign ng_pulse  = ng_s2_q & ~ng_prev_q;
    assign lfsr_fb   = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    assign att_inc   = attempts_q + 4'd1;

    always_comb begin
        sub_s1_d   = submit_btn;
        sub_s2_d   = sub_s1_q;
        sub_prev_d = sub_s2_q;
        ng_s1_d    = newgame_btn;
        ng_s2_d    = ng_s1_q;
        ng_prev_d  = ng_s2_q;
        lfsr_d     = lfsr_q;
        state_d    = state_q;
        result_d   = result_q;
        attempts_d = attempts_q;
        secret_d   = secret_q;

        if (ena) begin
            lfsr_d = {lfsr_q[14:0], lfsr_fb};
            // New game has priority over a coincident submit in every state.
            if (ng_pulse) begin
                state_d    = ST_PLAY;
                secret_d   = lfsr_q[GUESS_W-1:0];
                attempts_d = 4'd0;
                result_d   = RES_NONE;
            end else if (sub_pulse && state_q == ST_PLAY) begin
                attempts_d = att_inc;
                if (guess_in == secret_q) begin
                    result_d = RES_OK;
                    state_d  = ST_WON;
                end else begin
                    result_d = (guess_in < secret_q) ? RES_LOW : RES_HIGH;
                    if (att_inc == MAX_T) begin
                        state_d = ST_LOST;
                    end
                end
            end
        end

        // Glyph follows the next state so it changes on the same edge as game_state.
        seg_d = SEG_DASH;
        case (state_d)
            ST_PLAY: begin
                if (result_d == RES_LOW) begin
                    seg_d = SEG_L;
                end else if (result_d == RES_HIGH) begin
                    seg_d = SEG_H;
                end
            end
            ST_WON:  seg_d = SEG_C;
            ST_LOST: seg_d = SEG_E;
            default: seg_d = SEG_DASH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sub_s1_q   <= 1'b0;
            sub_s2_q   <= 1'b0;
            sub_prev_q <= 1'b0;
            ng_s1_q    <= 1'b0;
            ng_s2_q    <= 1'b0;
            ng_prev_q  <= 1'b0;
            lfsr_q     <= LFSR_SEED;
            state_q    <= ST_IDLE;
            result_q   <= RES_NONE;
            attempts_q <= 4'd0;
            secret_q   <= '0;
            seg_q      <= SEG_DASH;
        end else begin
            sub_s1_q   <= sub_s1_d;
            sub_s2_q   <= sub_s2_d;
            sub_prev_q <= sub_prev_d;
            ng_s1_q    <= ng_s1_d;
            ng_s2_q    <= ng_s2_d;
            ng_prev_q  <= ng_prev_d;
            lfsr_q     <= lfsr_d;
            state_q    <= state_d;
            result_q   <= result_d;
            attempts_q <= attempts_d;
            secret_q   <= secret_d;
            seg_q      <= seg_d;
        end
    end

    assign result     = result_q;
    assign attempts   = attempts_q;
    assign game_state = state_q;
    assign seg        = seg_q;
    assign secret_o   = secret_q;

endmodule

// File: tb/tb_guess_engine.sv
// Directed table-driven bench for guess_engine with an independent LFSR reference for the secret.
module tb_guess_engine;

    logic       clk = 1'b0;
    logic       rst_n, ena, submit_btn, newgame_btn;
    logic [5:0] guess_in;
    logic [1:0] result, game_state;
    logic [3:0] attempts;
    logic [6:0] seg;
    logic [5:0] secret_o;

    always #5 clk = ~clk;

    guess_engine #(.GUESS_W(6), .MAX_TRIES(8), .LFSR_SEED(16'hACE1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .guess_in   (guess_in),
        .submit_btn (submit_btn),
        .newgame_btn(newgame_btn),
        .result     (result),
        .attempts   (attempts),
        .game_state (game_state),
        .seg        (seg),
        .secret_o   (secret_o)
    );

    // Reference LFSR: 16-bit Fibonacci, taps 16,14,13,11, advancing on enabled cycles.
    logic [15:0] m_lfsr;
    always @(posedge clk) begin
        if (!rst_n) m_lfsr <= 16'hACE1;
        else if (ena) m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    int n_cmp = 0;
    int n_bad = 0;

    logic [1:0] st_exp, r_exp;
    logic [3:0] a_exp;
    logic [5:0] s_exp;

    typedef struct {
        int         delta;
        logic [3:0] att;
        logic [1:0] st;
        bit         keep;
        bit         ng;
    } vec_t;
    vec_t tab[14];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [1:0] st, input logic [1:0] r);
        case (st)
            2'b01:   seg_of = (r == 2'b01) ? 7'b0111000 : (r == 2'b10) ? 7'b1110110 : 7'b1000000;
            2'b10:   seg_of = 7'b0111001;
            2'b11:   seg_of = 7'b1111001;
            default: seg_of = 7'b1000000;
        endcase
    endfunction

    function automatic logic [1:0] cmp_code(input logic [5:0] g, input logic [5:0] s);
        cmp_code = (g == s) ? 2'b11 : (g < s) ? 2'b01 : 2'b10;
    endfunction

    task automatic check_all(input string nm);
        chk({nm, ".state"},    16'(game_state), 16'(st_exp));
        chk({nm, ".result"},   16'(result),     16'(r_exp));
        chk({nm, ".attempts"}, 16'(attempts),   16'(a_exp));
        chk({nm, ".seg"},      16'(seg),        16'(seg_of(st_exp, r_exp)));
        chk({nm, ".secret"},   16'(secret_o),   16'(s_exp));
    endtask

    task automatic do_newgame(input string nm, input int hold);
        logic [5:0] s_next;
        @(negedge clk) newgame_btn = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk) s_next = m_lfsr[5:0];
        @(posedge clk) #1;
        st_exp = 2'b01; r_exp = 2'b00; a_exp = 4'd0; s_exp = s_next;
        check_all(nm);
        if (hold > 3) repeat (hold - 3) @(posedge clk);
        @(negedge clk) newgame_btn = 1'b0;
        repeat (4) @(posedge clk);
        #1 check_all({nm, "_held"});
    endtask

    task automatic do_submit(input string nm, input logic [5:0] g);
        @(negedge clk) begin guess_in = g; submit_btn = 1'b1; end
        repeat (3) @(posedge clk);
        #1 check_all(nm);
        @(negedge clk) submit_btn = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [5:0] g;
        logic [5:0] s_next;

        tab[0]  = '{-1,  4'd1, 2'b01, 1'b0, 1'b0};
        tab[1]  = '{ 1,  4'd2, 2'b01, 1'b0, 1'b0};
        tab[2]  = '{ 0,  4'd3, 2'b10, 1'b0, 1'b0};
        tab[3]  = '{ 5,  4'd3, 2'b10, 1'b1, 1'b0};
        tab[4]  = '{ 0,  4'd0, 2'b01, 1'b0, 1'b1};
        tab[5]  = '{-3,  4'd1, 2'b01, 1'b0, 1'b0};
        tab[6]  = '{ 7,  4'd2, 2'b01, 1'b0, 1'b0};
        tab[7]  = '{-10, 4'd3, 2'b01, 1'b0, 1'b0};
        tab[8]  = '{ 2,  4'd4, 2'b01, 1'b0, 1'b0};
        tab[9]  = '{-1,  4'd5, 2'b01, 1'b0, 1'b0};
        tab[10] = '{ 20, 4'd6, 2'b01, 1'b0, 1'b0};
        tab[11] = '{-30, 4'd7, 2'b01, 1'b0, 1'b0};
        tab[12] = '{ 1,  4'd8, 2'b11, 1'b0, 1'b0};
        tab[13] = '{ 4,  4'd8, 2'b11, 1'b1, 1'b0};

        rst_n = 1'b0; ena = 1'b1; submit_btn = 1'b0; newgame_btn = 1'b0; guess_in = '0;
        st_exp = 2'b00; r_exp = 2'b00; a_exp = 4'd0; s_exp = 6'd0;
        repeat (4) @(posedge clk);
        #1 check_all("reset");
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);

        do_newgame("newgame", 5);

        for (int i = 0; i < 14; i++) begin
            if (tab[i].ng) begin
                do_newgame($sformatf("vec%0d_ng", i), 3);
            end else begin
                g = s_exp + 6'(tab[i].delta);
                if (!tab[i].keep) r_exp = cmp_code(g, s_exp);
                a_exp  = tab[i].att;
                st_exp = tab[i].st;
                do_submit($sformatf("vec%0d", i), g);
            end
        end

        // Restart from LOST, make one guess, then press both buttons together.
        do_newgame("ng_from_lost", 3);
        g = s_exp + 6'd1;
        r_exp = cmp_code(g, s_exp); a_exp = 4'd1;
        do_submit("pre_simul", g);
        @(negedge clk) begin newgame_btn = 1'b1; submit_btn = 1'b1; guess_in = s_exp; end
        repeat (2) @(posedge clk);
        @(negedge clk) s_next = m_lfsr[5:0];
        @(posedge clk) #1;
        st_exp = 2'b01; r_exp = 2'b00; a_exp = 4'd0; s_exp = s_next;
        check_all("simul");
        @(negedge clk) begin newgame_btn = 1'b0; submit_btn = 1'b0; end
        repeat (4) @(posedge clk);
        #1 check_all("simul_after");

        // Submit while disabled must be lost, even after ena returns.
        @(negedge clk) begin ena = 1'b0; guess_in = s_exp + 6'd2; submit_btn = 1'b1; end
        repeat (3) @(posedge clk);
        #1 check_all("ena0");
        @(negedge clk) submit_btn = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk) ena = 1'b1;
        repeat (4) @(posedge clk);
        #1 check_all("ena0_after");
        g = s_exp + 6'd2;
        r_exp = cmp_code(g, s_exp); a_exp = 4'd1;
        do_submit("ena1_submit", g);

        // Reset lands on the edge where a submit pulse would be acted on.
        @(negedge clk) begin guess_in = s_exp - 6'd1; submit_btn = 1'b1; end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b0;
        @(posedge clk) #1;
        st_exp = 2'b00; r_exp = 2'b00; a_exp = 4'd0; s_exp = 6'd0;
        check_all("rst_mid");
        @(negedge clk) submit_btn = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1 check_all("rst_after");

        // Submit in IDLE is ignored.
        do_submit("idle_submit", 6'd9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
